// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, protocol bytes and vote helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Bytes exchanged with the peer board; also used by the game master and TX side
  localparam logic [7:0] HANDSHAKE_ACK = 8'hA5;
  localparam logic [7:0] ACT_ATTACK    = 8'h20;
  localparam logic [7:0] ACT_HIT       = 8'h10;

  // 2-of-3 majority of three consecutive oversamples
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle for the UART receiver
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  // master drives the line and consumes bytes; slave is the receiver
  modport master (output rxd, input rx_data, input rx_valid, input frame_err, input busy);
  modport slave  (input rxd, output rx_data, output rx_valid, output frame_err, output busy);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick, one pulse every DIV clocks
module uart_baud_tick #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  // Rounded divide so the tick period is the nearest whole number of clocks
  localparam int DIV = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and emit a registered tick on the wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and majority vote
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);
  localparam int SW = $clog2(OVS);
  // The vote is resolved on the tick after mid-bit, once ticks OVS/2-1..OVS/2+1 are in
  localparam logic [SW-1:0] VOTE_IDX = SW'(OVS / 2 + 1);

  rx_state_t     state, state_next;
  logic [1:0]    sync;
  logic          rxd_s;
  logic          tick;
  logic [SW-1:0] sample_cnt;
  logic [SW-1:0] idx;
  logic [2:0]    hist;
  logic [2:0]    hist_new;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          vote_now;
  logic          vote;
  logic          got_byte;
  logic          got_err;

  uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rxd_s    = sync[1];
  assign idx      = sample_cnt + 1'b1;
  assign hist_new = {hist[1:0], rxd_s};
  assign vote_now = tick && (idx == VOTE_IDX);
  assign vote     = maj3(hist_new);

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);

  // Two-flop synchronizer on the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bus.rxd};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus byte/error strobes; the stop vote returns to IDLE at mid-bit
  always_comb begin
    state_next = state;
    got_byte   = 1'b0;
    got_err    = 1'b0;
    case (state)
      IDLE:      if (tick && !rxd_s) state_next = START;
      START:     if (vote_now) state_next = vote ? IDLE : DATA;
      DATA:      if (vote_now && bit_cnt == 3'd7) state_next = STOP;
      STOP: begin
        if (vote_now) begin
          if (vote) begin
            state_next = IDLE;
            got_byte   = 1'b1;
          end else begin
            state_next = WAIT_IDLE;
            got_err    = 1'b1;
          end
        end
      end
      WAIT_IDLE: if (tick && rxd_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Oversample counting, bit shifting and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      hist       <= 3'b111;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= got_byte;
      err_q   <= got_err;
      if (got_byte) data_q <= shreg;
      if (tick) begin
        hist <= hist_new;
        // Counting simply continues modulo OVS, so each later vote is one bit apart
        sample_cnt <= (state == IDLE) ? '0 : idx;
      end
      if (state == START && vote_now) bit_cnt <= '0;
      if (state == DATA && vote_now) begin
        shreg   <= {vote, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115200;
  localparam int OVS    = 16;
  localparam int DIV    = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int BIT_IDEAL = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BIT_FAST  = 425;
  localparam int BIT_SLOW  = 443;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] last_good = 8'h00;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         data_bad = 0;
  logic [7:0] prev_data = 8'h00;
  logic       rst_q = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        got_q.push_back(bus.rx_data);
        got_cyc.push_back(cyc);
      end
      if (bus.frame_err) err_cnt++;
      if (bus.rx_valid && bus.frame_err) both_cnt++;
      if (!rst_q && bus.rx_data !== prev_data && !bus.rx_valid) data_bad++;
    end
    prev_data = bus.rx_data;
    rst_q     = rst;
  end

  task automatic line(input logic v, input int n);
    bus.rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_val);
    start_q.push_back(cyc);
    line(1'b0, bc);
    for (int i = 0; i < 8; i++) line(b[i], bc);
    line(stop_val, bc);
    if (stop_val) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic clear_model();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    start_q.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    bus.rxd = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", bus.rx_valid); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    line(1'b1, 2 * BIT_IDEAL);
  endtask

  task automatic test_single();
    int lat;
    int want;
    clear_model();
    send_frame(HANDSHAKE_ACK, BIT_IDEAL, 1'b1);
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_data got %h want %h", got_q[0], exp_q[0]); end
      lat  = got_cyc[0] - start_q[0];
      want = (19 * BIT_IDEAL) / 2;
      n_checks++;
      if (lat < want - 2 * DIV || lat > want + 2 * DIV + 4) begin
        n_fail++; $display("FAIL single_latency got %0d clk want %0d +-%0d", lat, want, 2 * DIV);
      end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", err_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int gap;
    clear_model();
    send_frame(ACT_HIT, BIT_IDEAL, 1'b1);
    send_frame(ACT_ATTACK, BIT_IDEAL, 1'b1);
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data0 got %h want %h", got_q[0], exp_q[0]); end
      n_checks++; if (got_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL b2b_data1 got %h want %h", got_q[1], exp_q[1]); end
      gap = got_cyc[1] - got_cyc[0];
      n_checks++;
      if (gap < 10 * BIT_IDEAL - DIV - 2 || gap > 10 * BIT_IDEAL + DIV + 2) begin
        n_fail++; $display("FAIL b2b_spacing got %0d clk want %0d +-%0d", gap, 10 * BIT_IDEAL, DIV);
      end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL b2b_frame_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_glitch();
    clear_model();
    line(1'b0, 4 * DIV);
    line(1'b1, 2 * DIV);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high got %b want 1", bus.busy); end
    line(1'b1, 6 * DIV);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low got %b want 0", bus.busy); end
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", got_q.size()); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL glitch_frame_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_break();
    clear_model();
    send_frame(8'h55, BIT_IDEAL, 1'b0);
    line(1'b0, 30 * BIT_IDEAL);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL break_err_count got %0d want 1", err_cnt); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL break_valid got %0d want 0", got_q.size()); end
    n_checks++; if (bus.rx_data !== last_good) begin n_fail++; $display("FAIL break_rx_data got %h want %h", bus.rx_data, last_good); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_held got %b want 1", bus.busy); end
    line(1'b1, 2 * BIT_IDEAL);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL break_release got %b want 0", bus.busy); end
    send_frame(HANDSHAKE_ACK, BIT_IDEAL, 1'b1);
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL break_recover_count got %0d want 1", got_q.size()); end
    if (got_q.size() == 1) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL break_recover_data got %h want %h", got_q[0], exp_q[0]); end
    end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL break_err_total got %0d want 1", err_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_model();
    b = 8'h3C;
    line(1'b0, BIT_IDEAL);
    for (int i = 0; i < 4; i++) line(b[i], BIT_IDEAL);
    line(b[4], BIT_IDEAL / 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data got %h want 00", bus.rx_data); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses got %b%b want 00", bus.rx_valid, bus.frame_err); end
    rst = 1'b0;
    last_good = 8'h00;
    line(1'b1, 2 * BIT_IDEAL);
    send_frame(8'hC3, BIT_IDEAL, 1'b1);
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", got_q.size()); end
    n_checks++; if (bus.rx_data !== 8'hC3) begin n_fail++; $display("FAIL midrst_next_data got %h want c3", bus.rx_data); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL midrst_frame_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_baud_tolerance();
    int rates[2];
    rates[0] = BIT_FAST;
    rates[1] = BIT_SLOW;
    for (int r = 0; r < 2; r++) begin
      clear_model();
      send_frame(8'h5A, rates[r], 1'b1);
      line(1'b1, rates[r]);
      n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL baud_count bit=%0d got %0d want 1", rates[r], got_q.size()); end
      n_checks++; if (bus.rx_data !== exp_q[0]) begin n_fail++; $display("FAIL baud_data bit=%0d got %h want %h", rates[r], bus.rx_data, exp_q[0]); end
      n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL baud_frame_err bit=%0d got %0d want 0", rates[r], err_cnt); end
    end
  endtask

  task automatic test_random();
    int bc;
    logic [7:0] b;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      bc = $urandom_range(BIT_SLOW, BIT_FAST);
      b  = 8'($urandom);
      send_frame(b, bc, 1'b1);
      if ($urandom_range(1, 0) == 1) line(1'b1, bc);
    end
    line(1'b1, BIT_IDEAL);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
    end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL rand_frame_err got %0d want 0", err_cnt); end
  endtask

  initial begin
    bus.rxd = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_baud_tolerance();
    test_random();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL valid_and_err_same_cycle got %0d want 0", both_cnt); end
    n_checks++; if (data_bad != 0) begin n_fail++; $display("FAIL rx_data_changed_without_valid got %0d want 0", data_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that turns the asynchronous `rxd` line from the peer board into single-byte `rx_data`/`rx_valid` pulses. It sits directly upstream of the game master FSM and feeds its receive port, which carries the handshake byte 8'hA5 and remote player action bytes. Frame format is 8N1, LSB first, with 16x oversampling and majority-vote sampling. Framing errors are flagged and never delivered as data.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency
- `BAUD`, 115200, line rate
- `OVS`, 16, oversample ticks per bit (power of two, ≥8)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rxd`  in  1  asynchronous serial line, idle high
- `rx_data`  out  8  last good byte; holds until next good byte
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid this cycle
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `busy`  out  1  high from start-bit detect until return to IDLE

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) before any use.
- Tick generator: `DIV = round(CLK_HZ/(BAUD*OVS))`, which is 27 at the defaults. It produces a 1-cycle `tick` every DIV clocks, free-running and independent of frame state.
- `sample_cnt` is a counter of width log2(OVS). `bit_cnt` is a 3-bit counter.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - The synchronized line is sampled on each tick.
  - A low sample moves to START and sets `sample_cnt`=0.
- START:
  - Count ticks.
  - At `sample_cnt`=OVS/2 (the mid-bit point), take a majority vote of ticks OVS/2−1, OVS/2 and OVS/2+1.
  - Vote high: treat as a glitch and return to IDLE with no output.
  - Vote low: go to DATA with `bit_cnt`=0 and re-align `sample_cnt` so the next mid-bit vote lands at the centre of bit 0.
- DATA:
  - For each bit, take the mid-bit majority vote and shift it into the MSB of the shift register. Data is LSB first, so after 8 bits the register holds the byte.
  - After bit 7 (`bit_cnt` wraps 7→0), go to STOP.
- STOP:
  - Take the mid-bit majority vote on the stop bit.
  - Vote high: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - Vote low: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until one tick samples the line high, then go to IDLE. A break condition (line held low) therefore produces exactly one `frame_err`.
- Returning to IDLE at the stop-bit midpoint, not the end, allows the next start edge to be caught with zero inter-frame gap.
- `busy` is 1 in every state except IDLE.
- Simultaneous events:
  - `rst` overrides everything.
  - `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - Synchronizer flops=1, all counters 0.
- Reset mid-frame: on the next edge, return to IDLE with outputs at reset values. The partial byte is discarded.
- Start-detect latency: 2 clk (synchronizer) plus up to one tick period.
- Byte latency: `rx_valid` rises within one clk of the tick at the stop-bit mid-sample. That is ≈9.5 bit periods after the start-bit falling edge, ±1 tick.
- `rx_valid`/`frame_err` are registered. Each is high for exactly one clk, on a clk edge, never held.
- `rx_data` changes only in the cycle `rx_valid` rises.
- Baud tolerance: correct reception for transmitter rate error up to ±2% at OVS=16.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` (IDLE, START, DATA, STOP, WAIT_IDLE, 3 bits).
  - The shared constants `HANDSHAKE_ACK`=8'hA5, `ACT_ATTACK`=8'h20 and `ACT_HIT`=8'h10, also used by the game master and the TX side.
- Sub-module `uart_baud_tick` (params `CLK_HZ`, `BAUD`, `OVS`; ports `clk`, `rst`, `tick`) is shared with the future `uart_tx`.
- The synchronizer and FSM stay inline.

## Test plan
- Send 0xA5 at 115200 with an ideal line → exactly one `rx_valid`, `rx_data`=8'hA5, `frame_err` never high, `busy` low afterwards.
- Send 0x10 then 0x20 back-to-back with zero idle gap → two `rx_valid` pulses, data 8'h10 then 8'h20, spaced 10 bit periods ±1 tick.
- Drive a low glitch lasting 4 ticks on the idle line → no `rx_valid`, no `frame_err`, `busy` back to 0 at the start-bit midpoint.
- Send 0x55 with the stop bit forced low, then hold the line low for 3 bytes → one `frame_err`, `rx_data` keeps its previous value, FSM stays in WAIT_IDLE. After release, a subsequent 0xA5 is received correctly.
- Assert `rst` for one cycle at data bit 4 of 0x3C → next cycle all outputs are at reset values. The following full 0xC3 frame yields `rx_data`=8'hC3.
- Send 0x5A at BAUD×1.02 and then at BAUD×0.98 → `rx_data`=8'h5A both times with no `frame_err`.
